// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow errors and a synchronous flush.
module fifo_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int AE_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [WIDTH-1:0]           dataIn,
    output logic [WIDTH-1:0]           dataOut,
    output logic                       EMPTY,
    output logic                       FULL,
    output logic                       ALMOST_EMPTY,
    output logic                       ALMOST_FULL,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       OVERFLOW,
    output logic                       UNDERFLOW
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $fatal(1, "fifo_param: DEPTH must be a power of two >= 2");
        end
        if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_thresh
            $fatal(1, "fifo_param: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
        end
        if (WIDTH < 1) begin : g_bad_width
            $fatal(1, "fifo_param: WIDTH must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             rdOk;
    logic             wrOk;

    assign EMPTY        = (count == '0);
    assign FULL         = (count == DEPTH_C);
    assign ALMOST_EMPTY = (count <= AE_C);
    assign ALMOST_FULL  = (count >= AF_C);

    // A read on a full FIFO frees a slot, so a same-cycle write is still accepted.
    assign rdOk = en & rd & ~EMPTY;
    assign wrOk = en & wr & (~FULL | rdOk);

    always_ff @(posedge clk) begin
        if (wrOk && !flush && !rst) begin
            mem[wrPtr] <= dataIn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            dataOut   <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else if (flush) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (wrOk) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (rdOk) begin
                dataOut <= mem[rdPtr];
                rdPtr   <= rdPtr + AW'(1);
            end
            case ({wrOk, rdOk})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (en && wr && !wrOk) begin
                OVERFLOW <= 1'b1;
            end
            if (en && rd && EMPTY) begin
                UNDERFLOW <= 1'b1;
            end
        end
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
Parametrised synchronous FIFO that generalises the team's fixed 32-bit fifo to any data width and power-of-two depth. Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It is the standard buffering element between producer/consumer blocks sharing one clock. The en / wr / rd / dataIn / dataOut / EMPTY / FULL semantics are unchanged, so existing users drop in with default parameters.

Parameters:
WIDTH, 32, data word width in bits (>=1).
DEPTH, 8, number of entries; power of two, >=2.
AF_THRESH, 6, ALMOST_FULL asserts when count >= AF_THRESH; must satisfy AE_THRESH < AF_THRESH <= DEPTH.
AE_THRESH, 1, ALMOST_EMPTY asserts when count <= AE_THRESH.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  global enable; when 0, wr and rd are ignored.
flush  input  1  synchronous clear; independent of en.
wr  input  1  write request.
rd  input  1  read request.
dataIn  input  WIDTH  write data.
dataOut  output  WIDTH  registered read data.
EMPTY  output  1  count == 0.
FULL  output  1  count == DEPTH.
ALMOST_EMPTY  output  1  count <= AE_THRESH.
ALMOST_FULL  output  1  count >= AF_THRESH.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
OVERFLOW  output  1  sticky; a write was dropped.
UNDERFLOW  output  1  sticky; a read was rejected.

Behaviour:
- One clock; reset is asynchronous and active-high. On rst assertion, with no clock required: wptr=0, rptr=0, count=0, dataOut=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0. Memory contents are not reset.
- Priority per edge: rst > flush > normal operation.
- flush=1: pointers, count, OVERFLOW and UNDERFLOW clear. dataOut holds. wr and rd are ignored that cycle.
- en=0 with no flush: no state change. dataOut holds. Flags hold.
- rd_ok = en & rd & !EMPTY.
- wr_ok = en & wr & (!FULL | rd_ok). When full, a simultaneous read frees a slot and the write is accepted.
- Write path: on wr_ok, mem[wptr] <= dataIn and wptr <= wptr+1 mod DEPTH (natural wrap).
- Read path: on rd_ok, dataOut <= mem[rptr] and rptr <= rptr+1 mod DEPTH. Latency is 1: data is visible after the edge that accepts the read. dataOut holds when there is no rd_ok.
- Count update: count <= count + wr_ok - rd_ok. Simultaneous accepted read and write leave count unchanged.
- Read while empty: no bypass. A same-cycle write to an empty FIFO is stored, the read is rejected and UNDERFLOW sets.
- All flags are decoded from the registered count, so they are valid immediately after each edge and carry no extra latency.
- OVERFLOW sets on en & wr & !wr_ok. UNDERFLOW sets on en & rd & EMPTY. Both stay set until rst or flush.
- Elaboration: a DEPTH that is not a power of two, or a threshold that violates its constraint, triggers $error / $fatal.

Test Plan:
- Defaults. rst 100 ns, en=1, write 0x0..0x4 on consecutive edges, then rd=1 for 5 cycles. Required: count 5, EMPTY=0 after writes. dataOut = 0,1,2,3,4 on successive edges. EMPTY=1 and ALMOST_EMPTY=1 after the 5th read.
- Fill and overflow. Write 8 words. Required: ALMOST_FULL=1 at count 6, FULL=1 at count 8. A 9th write with rd=0 is dropped, count stays 8, OVERFLOW=1, and the next 8 reads return the first 8 words.
- Full with simultaneous rd&wr. Required: both accepted, count stays 8, FULL stays 1, dataOut = oldest word, and the new word is read last.
- Underflow. rd=1 while empty. Required: UNDERFLOW=1, dataOut unchanged, count 0. A later flush clears UNDERFLOW.
- Wrap-around. Write 6/read 6 three times with distinct data. Required: every read matches write order across the pointer wrap, and count returns to 0 each round.
- Control edge cases. en=0 with wr=rd=1 for 3 cycles: no change to count or dataOut. Assert rst asynchronously between edges with count=4: all outputs reach reset values before the next edge. flush with count=5: count=0 and EMPTY=1 after one edge.
